// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: synchronises entry/exit loop sensors, keeps the bay
// count, drives two timed gate actuators and optional 7-segment displays.
// Optional feature macro: PARK_SEG_DISPLAY_EN (BCD/segment display drive).
module parking_lot_ctrl #(
    parameter int unsigned CAPACITY  = 8,
    parameter int unsigned GATE_HOLD = 4,
    localparam int unsigned CW       = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          entry_sense,
    input  logic          exit_sense,
    output logic [CW-1:0] car_count,
    output logic [CW-1:0] empty_spaces,
    output logic          full,
    output logic          empty,
    output logic          entry_gate_open,
    output logic          exit_gate_open,
    output logic          entry_denied,
    output logic [13:0]   car_count_display,
    output logic [13:0]   empty_space_display
);

    localparam logic [CW-1:0] CapCount = CW'(CAPACITY);
    localparam logic [7:0]    HoldInit = 8'(GATE_HOLD - 1);

    typedef enum logic [0:0] {StClosed, StOpen} gate_state_e;

    logic [1:0]  entry_sync_q, exit_sync_q;
    logic        entry_prev_q, exit_prev_q;
    logic        entry_arm_q, exit_arm_q;
    logic        settle_q;
    logic        entry_ev, exit_ev;
    logic        entry_acc, exit_acc;
    logic [CW-1:0] count_q, count_d;
    logic        denied_q, denied_d;
    gate_state_e entry_state_q, entry_state_d, exit_state_q, exit_state_d;
    logic [7:0]  entry_timer_q, entry_timer_d, exit_timer_q, exit_timer_d;

    // Synchronisers, edge-detect history and post-reset arming.
    // A sensor is armed only once a low level is seen after the pipeline has
    // filled, so a sensor held high across reset release yields no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_sync_q <= 2'b00;
            exit_sync_q  <= 2'b00;
            entry_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
            entry_arm_q  <= 1'b0;
            exit_arm_q   <= 1'b0;
            settle_q     <= 1'b0;
        end else begin
            entry_sync_q <= {entry_sync_q[0], entry_sense};
            exit_sync_q  <= {exit_sync_q[0], exit_sense};
            entry_prev_q <= entry_sync_q[1];
            exit_prev_q  <= exit_sync_q[1];
            entry_arm_q  <= entry_arm_q | (settle_q & ~entry_sync_q[0]);
            exit_arm_q   <= exit_arm_q | (settle_q & ~exit_sync_q[0]);
            settle_q     <= 1'b1;
        end
    end

    assign entry_ev = entry_sync_q[1] & ~entry_prev_q & entry_arm_q;
    assign exit_ev  = exit_sync_q[1] & ~exit_prev_q & exit_arm_q;

    // Event arbitration and next count; simultaneous events always net to zero.
    always_comb begin
        count_d   = count_q;
        entry_acc = 1'b0;
        exit_acc  = 1'b0;
        denied_d  = 1'b0;
        if (entry_ev && exit_ev) begin
            entry_acc = 1'b1;
            exit_acc  = 1'b1;
        end else if (entry_ev) begin
            if (!full) begin
                entry_acc = 1'b1;
                count_d   = count_q + CW'(1);
            end else begin
                denied_d = 1'b1;
            end
        end else if (exit_ev) begin
            if (!empty) begin
                exit_acc = 1'b1;
                count_d  = count_q - CW'(1);
            end
        end
    end

    // Count and denial pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            denied_q <= denied_d;
        end
    end

    // Gate FSM state and hold timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_state_q <= StClosed;
            exit_state_q  <= StClosed;
            entry_timer_q <= '0;
            exit_timer_q  <= '0;
        end else begin
            entry_state_q <= entry_state_d;
            exit_state_q  <= exit_state_d;
            entry_timer_q <= entry_timer_d;
            exit_timer_q  <= exit_timer_d;
        end
    end

    // Entry gate: an accepted event opens or re-arms the full hold time.
    always_comb begin
        entry_state_d = entry_state_q;
        entry_timer_d = entry_timer_q;
        unique case (entry_state_q)
            StClosed: begin
                if (entry_acc) begin
                    entry_state_d = StOpen;
                    entry_timer_d = HoldInit;
                end
            end
            StOpen: begin
                if (entry_acc)                entry_timer_d = HoldInit;
                else if (entry_timer_q == '0) entry_state_d = StClosed;
                else                          entry_timer_d = entry_timer_q - 8'd1;
            end
            default: entry_state_d = StClosed;
        endcase
    end

    // Exit gate: same behaviour as the entry gate.
    always_comb begin
        exit_state_d = exit_state_q;
        exit_timer_d = exit_timer_q;
        unique case (exit_state_q)
            StClosed: begin
                if (exit_acc) begin
                    exit_state_d = StOpen;
                    exit_timer_d = HoldInit;
                end
            end
            StOpen: begin
                if (exit_acc)                exit_timer_d = HoldInit;
                else if (exit_timer_q == '0) exit_state_d = StClosed;
                else                         exit_timer_d = exit_timer_q - 8'd1;
            end
            default: exit_state_d = StClosed;
        endcase
    end

    assign car_count       = count_q;
    assign empty_spaces    = CapCount - count_q;
    assign full            = (count_q == CapCount);
    assign empty           = (count_q == '0);
    assign entry_gate_open = (entry_state_q == StOpen);
    assign exit_gate_open  = (exit_state_q == StOpen);
    assign entry_denied    = denied_q;

`ifdef PARK_SEG_DISPLAY_EN
    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] to_disp(input logic [CW-1:0] v);
        logic [6:0] v7;
        logic [3:0] tens, ones;
        v7   = 7'(v);
        tens = 4'(v7 / 7'd10);
        ones = 4'(v7 % 7'd10);
        return {(v7 < 7'd10) ? 7'b1111111 : seg7(tens), seg7(ones)};
    endfunction

    // Two-digit displays of occupied and free bays.
    always_comb begin
        car_count_display   = to_disp(count_q);
        empty_space_display = to_disp(empty_spaces);
    end
`else
    assign car_count_display   = '1;
    assign empty_space_display = '1;
`endif

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Randomised self-checking bench for parking_lot_ctrl with a sample-history
// reference model; also covers the directed corner cases.
module tb_parking_lot_ctrl;

    localparam int CAP  = 8;
    localparam int HOLD = 4;
    localparam int CW   = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          entry_sense, exit_sense;
    logic [CW-1:0] car_count, empty_spaces;
    logic          full, empty, entry_gate_open, exit_gate_open, entry_denied;
    logic [13:0]   car_count_display, empty_space_display;

    logic          e12, x12;
    logic [3:0]    c12_count, c12_spaces;
    logic          c12_full, c12_empty, c12_gin, c12_gout, c12_denied;
    logic [13:0]   c12_cdisp, c12_sdisp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    parking_lot_ctrl #(.CAPACITY(CAP), .GATE_HOLD(HOLD)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .entry_sense         (entry_sense),
        .exit_sense          (exit_sense),
        .car_count           (car_count),
        .empty_spaces        (empty_spaces),
        .full                (full),
        .empty               (empty),
        .entry_gate_open     (entry_gate_open),
        .exit_gate_open      (exit_gate_open),
        .entry_denied        (entry_denied),
        .car_count_display   (car_count_display),
        .empty_space_display (empty_space_display)
    );

    parking_lot_ctrl #(.CAPACITY(12), .GATE_HOLD(HOLD)) u_dut12 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .entry_sense         (e12),
        .exit_sense          (x12),
        .car_count           (c12_count),
        .empty_spaces        (c12_spaces),
        .full                (c12_full),
        .empty               (c12_empty),
        .entry_gate_open     (c12_gin),
        .exit_gate_open      (c12_gout),
        .entry_denied        (c12_denied),
        .car_count_display   (c12_cdisp),
        .empty_space_display (c12_sdisp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: counts rises seen in the sensor sample history.
    int m_count, m_gin, m_gout, m_edges;
    bit m_denied;
    bit eh1, eh2, eh3, xh1, xh2, xh3;

    task automatic model_reset();
        m_count = 0; m_gin = 0; m_gout = 0; m_edges = 0; m_denied = 0;
        eh1 = 0; eh2 = 0; eh3 = 0; xh1 = 0; xh2 = 0; xh3 = 0;
    endtask

    // A rise is a low sample followed by a high sample, both taken after reset
    // release; it takes effect two edges after the high sample.
    task automatic model_step();
        bit en_ev, ex_ev, en_acc, ex_acc;
        en_ev    = (m_edges >= 3) && eh2 && !eh3;
        ex_ev    = (m_edges >= 3) && xh2 && !xh3;
        en_acc   = en_ev && (ex_ev || m_count < CAP);
        ex_acc   = ex_ev && (en_ev || m_count > 0);
        m_denied = en_ev && !ex_ev && (m_count == CAP);
        m_count  = m_count + int'(en_acc) - int'(ex_acc);
        m_gin    = en_acc ? HOLD : (m_gin > 0 ? m_gin - 1 : 0);
        m_gout   = ex_acc ? HOLD : (m_gout > 0 ? m_gout - 1 : 0);
        eh3 = eh2; eh2 = eh1; eh1 = entry_sense;
        xh3 = xh2; xh2 = xh1; xh1 = exit_sense;
        m_edges++;
    endtask

    always @(posedge clk) if (rst_n) model_step();

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] exp_disp(input int v);
`ifdef PARK_SEG_DISPLAY_EN
        return {(v < 10) ? 7'b1111111 : seg_ref(v / 10), seg_ref(v % 10)};
`else
        return (v >= 0) ? 14'h3fff : 14'h3fff;
`endif
    endfunction

    task automatic compare_all();
        check_eq("car_count", 32'(car_count), m_count);
        check_eq("empty_spaces", 32'(empty_spaces), CAP - m_count);
        check_eq("full", 32'(full), 32'(m_count == CAP));
        check_eq("empty", 32'(empty), 32'(m_count == 0));
        check_eq("entry_gate_open", 32'(entry_gate_open), 32'(m_gin > 0));
        check_eq("exit_gate_open", 32'(exit_gate_open), 32'(m_gout > 0));
        check_eq("entry_denied", 32'(entry_denied), 32'(m_denied));
        check_eq("car_count_display", 32'(car_count_display), 32'(exp_disp(m_count)));
        check_eq("empty_space_display", 32'(empty_space_display), 32'(exp_disp(CAP - m_count)));
    endtask

    // Drive at a falling edge, advance one cycle, compare at the next falling edge.
    task automatic step(input bit en, input bit ex);
        entry_sense = en;
        exit_sense  = ex;
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        model_reset();
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 0);
    endtask

    int gin_cyc, gout_cyc, den;

    initial begin
        rst_n = 1'b0; entry_sense = 0; exit_sense = 0; e12 = 0; x12 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check_eq("reset_count_disp", 32'(car_count_display), 32'(exp_disp(0)));
        check_eq("reset_space_disp", 32'(empty_space_display), 32'(exp_disp(8)));
        rst_n = 1'b1;
        repeat (3) step(0, 0);

        // Single 5-cycle entry pulse.
        gin_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            step(i < 5, 0);
            if (i == 1) check_eq("count_before_3rd_edge", 32'(car_count), 0);
            if (i == 2) check_eq("count_at_3rd_edge", 32'(car_count), 1);
            if (entry_gate_open) gin_cyc++;
        end
        check_eq("single_gate_cycles", gin_cyc, HOLD);

        // Nine entries into an eight-bay lot.
        reset_dut();
        den = 0;
        for (int p = 0; p < 9; p++) begin
            gin_cyc = 0;
            for (int c = 0; c < 6; c++) begin
                step(c < 3, 0);
                if (entry_denied) den++;
                if (entry_gate_open) gin_cyc++;
            end
            if (p == 8) check_eq("denied_gate_cycles", gin_cyc, 0);
        end
        check_eq("full_count", 32'(car_count), CAP);
        check_eq("full_flag", 32'(full), 1);
        check_eq("denied_pulses", den, 1);

        // Simultaneous entry and exit while full.
        gin_cyc = 0; gout_cyc = 0; den = 0;
        for (int i = 0; i < 10; i++) begin
            step(i < 3, i < 3);
            if (entry_gate_open) gin_cyc++;
            if (exit_gate_open) gout_cyc++;
            if (entry_denied) den++;
        end
        check_eq("simul_count", 32'(car_count), CAP);
        check_eq("simul_entry_gate", gin_cyc, HOLD);
        check_eq("simul_exit_gate", gout_cyc, HOLD);
        check_eq("simul_denied", den, 0);

        // Exit at an empty lot.
        reset_dut();
        gout_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, i < 3);
            if (exit_gate_open) gout_cyc++;
        end
        check_eq("empty_exit_count", 32'(car_count), 0);
        check_eq("empty_exit_gate", gout_cyc, 0);

        // Randomised traffic.
        reset_dut();
        for (int s = 0; s < 600; s++) begin
            bit en, ex;
            int len;
            en  = 1'($urandom_range(0, 1));
            ex  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            repeat (len) step(en, ex);
        end
        repeat (8) step(0, 0);

        // Reset during gate hold with the sensor held high.
        reset_dut();
        repeat (4) step(1, 0);
        check_eq("gate_open_before_reset", 32'(entry_gate_open), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("gate_async_close", 32'(entry_gate_open), 0);
        check_eq("count_async_clear", 32'(car_count), 0);
        step(1, 0);
        step(1, 0);
        rst_n = 1'b1;
        repeat (8) step(1, 0);
        check_eq("no_event_held_high", 32'(car_count), 0);
        repeat (2) step(0, 0);
        repeat (6) step(1, 0);
        check_eq("event_after_refall", 32'(car_count), 1);
        repeat (4) step(0, 0);

        // Second instance, twelve bays: eleven entries.
        for (int p = 0; p < 11; p++) begin
            for (int c = 0; c < 6; c++) begin
                e12 = (c < 3);
                step(0, 0);
            end
        end
        e12 = 0;
        repeat (4) step(0, 0);
        check_eq("cap12_count", 32'(c12_count), 11);
        check_eq("cap12_spaces", 32'(c12_spaces), 1);
`ifdef PARK_SEG_DISPLAY_EN
        check_eq("cap12_display", 32'(c12_cdisp), 32'({7'b1111001, 7'b1111001}));
`else
        check_eq("cap12_display", 32'(c12_cdisp), 32'(14'h3fff));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
